// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for uart_receiver: programs the baud code, gates Rx_EN and packs
// MSG_BYTES received bytes into one message word delivered over valid/ready.
// Define UART_RX_CTRL_STATS_EN to enable the good/error message counters.
module uart_rx_ctrl #(
   parameter int MSG_BYTES      = 4,
   parameter int TIMEOUT_CYCLES = 8680
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   cfg_wr,
   input  logic [2:0]             cfg_baud,
   output logic [2:0]             baud_select,
   output logic                   Rx_EN,
   input  logic [7:0]             Rx_DATA,
   input  logic                   Rx_VALID,
   input  logic                   Rx_FERROR,
   input  logic                   Rx_PERROR,
   output logic [8*MSG_BYTES-1:0] msg_data,
   output logic [4:0]             msg_count,
   output logic                   msg_valid,
   input  logic                   msg_ready,
   output logic                   msg_err,
   output logic [1:0]             err_code,
   output logic                   busy,
   output logic [15:0]            stat_good,
   output logic [15:0]            stat_err,
   input  logic                   stats_clr
);

   localparam int DATA_W  = 8 * MSG_BYTES;
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DELIVER = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [2:0]          baud_r, baud_s;
   logic                rx_en_r;
   logic                busy_r;
   logic                valid_q_r, ferr_q_r, perr_q_r;
   logic [DATA_W-1:0]   msg_data_r, msg_data_s;
   logic [4:0]          msg_count_r, msg_count_s;
   logic                msg_valid_r, msg_valid_s;
   logic                msg_err_r, msg_err_s;
   logic [1:0]          err_code_r, err_code_s;
   logic [TIMER_W-1:0]  timer_r, timer_s;
   logic [15:0]         stat_good_r, stat_err_r;

   logic                byte_ev_s;
   logic                bad_ev_s;
   logic                timer_run_s;
   logic                timer_exp_s;
   logic                handshake_s;

   // Framing has priority over parity when both flags are raised together.
   function automatic logic [1:0] classify_err(input logic ferr, input logic perr);
      logic [1:0] code;
      if (ferr) begin
         code = 2'b01;
      end else if (perr) begin
         code = 2'b10;
      end else begin
         code = 2'b00;
      end
      return code;
   endfunction

   // Byte event detection and timer status
   always_comb begin
      byte_ev_s   = (Rx_VALID & ~valid_q_r) | (Rx_FERROR & ~ferr_q_r) | (Rx_PERROR & ~perr_q_r);
      bad_ev_s    = byte_ev_s & (Rx_FERROR | Rx_PERROR);
      timer_run_s = (msg_count_r >= 5'd1) && (msg_count_r < 5'(MSG_BYTES));
      timer_exp_s = timer_run_s && (timer_r == TIMER_W'(TIMEOUT_CYCLES - 1));
      handshake_s = (state_r == ST_DELIVER) && msg_valid_r && msg_ready;
   end

   // Next-state and next-output logic
   always_comb begin
      state_s     = state_r;
      baud_s      = baud_r;
      msg_data_s  = msg_data_r;
      msg_count_s = msg_count_r;
      msg_valid_s = msg_valid_r;
      msg_err_s   = msg_err_r;
      err_code_s  = err_code_r;
      timer_s     = timer_r;
      case (state_r)
         ST_IDLE: begin
            if (cfg_wr) begin
               baud_s = cfg_baud;
            end else begin
               baud_s = baud_r;
            end
            if (enable) begin
               state_s = ST_COLLECT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (!enable) begin
               // Abort drops the partial message entirely.
               state_s     = ST_IDLE;
               msg_count_s = 5'd0;
               timer_s     = '0;
            end else if (bad_ev_s) begin
               state_s     = ST_DELIVER;
               msg_valid_s = 1'b1;
               msg_err_s   = 1'b1;
               err_code_s  = classify_err(Rx_FERROR, Rx_PERROR);
            end else if (byte_ev_s) begin
               for (int i = 0; i < MSG_BYTES; i++) begin
                  if (msg_count_r == 5'(i)) begin
                     msg_data_s[8*i +: 8] = Rx_DATA;
                  end else begin
                     msg_data_s[8*i +: 8] = msg_data_r[8*i +: 8];
                  end
               end
               msg_count_s = msg_count_r + 5'd1;
               timer_s     = '0;
               if (msg_count_r == 5'(MSG_BYTES - 1)) begin
                  state_s     = ST_DELIVER;
                  msg_valid_s = 1'b1;
               end else begin
                  state_s = ST_COLLECT;
               end
            end else if (timer_exp_s) begin
               state_s     = ST_DELIVER;
               msg_valid_s = 1'b1;
               msg_err_s   = 1'b1;
               err_code_s  = 2'b11;
            end else if (timer_run_s) begin
               timer_s = timer_r + TIMER_W'(1);
            end else begin
               timer_s = timer_r;
            end
         end
         ST_DELIVER: begin
            if (handshake_s) begin
               msg_valid_s = 1'b0;
               msg_err_s   = 1'b0;
               err_code_s  = 2'b00;
               msg_count_s = 5'd0;
               timer_s     = '0;
               if (enable) begin
                  state_s = ST_COLLECT;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_DELIVER;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            msg_valid_s = 1'b0;
            msg_err_s   = 1'b0;
            err_code_s  = 2'b00;
            msg_count_s = 5'd0;
            timer_s     = '0;
         end
      endcase
   end

   // State and output registers; Rx_EN and busy follow the next state so they align with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         baud_r      <= 3'b111;
         rx_en_r     <= 1'b0;
         busy_r      <= 1'b0;
         valid_q_r   <= 1'b0;
         ferr_q_r    <= 1'b0;
         perr_q_r    <= 1'b0;
         msg_data_r  <= '0;
         msg_count_r <= 5'd0;
         msg_valid_r <= 1'b0;
         msg_err_r   <= 1'b0;
         err_code_r  <= 2'b00;
         timer_r     <= '0;
      end else begin
         state_r     <= state_s;
         baud_r      <= baud_s;
         rx_en_r     <= (state_s == ST_COLLECT);
         busy_r      <= (state_s != ST_IDLE);
         valid_q_r   <= Rx_VALID;
         ferr_q_r    <= Rx_FERROR;
         perr_q_r    <= Rx_PERROR;
         msg_data_r  <= msg_data_s;
         msg_count_r <= msg_count_s;
         msg_valid_r <= msg_valid_s;
         msg_err_r   <= msg_err_s;
         err_code_r  <= err_code_s;
         timer_r     <= timer_s;
      end
   end

`ifdef UART_RX_CTRL_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

   // Delivered-message counters, clear wins over increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_good_r <= 16'd0;
         stat_err_r  <= 16'd0;
      end else if (stats_clr) begin
         stat_good_r <= 16'd0;
         stat_err_r  <= 16'd0;
      end else if (handshake_s && msg_err_r) begin
         stat_good_r <= stat_good_r;
         stat_err_r  <= sat_inc(stat_err_r);
      end else if (handshake_s) begin
         stat_good_r <= sat_inc(stat_good_r);
         stat_err_r  <= stat_err_r;
      end else begin
         stat_good_r <= stat_good_r;
         stat_err_r  <= stat_err_r;
      end
   end
`else
   // Counters are held at zero when statistics are not built in
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_good_r <= 16'd0;
         stat_err_r  <= 16'd0;
      end else if (stats_clr | handshake_s) begin
         stat_good_r <= 16'd0;
         stat_err_r  <= 16'd0;
      end else begin
         stat_good_r <= 16'd0;
         stat_err_r  <= 16'd0;
      end
   end
`endif

   assign baud_select = baud_r;
   assign Rx_EN       = rx_en_r;
   assign busy        = busy_r;
   assign msg_data    = msg_data_r;
   assign msg_count   = msg_count_r;
   assign msg_valid   = msg_valid_r;
   assign msg_err     = msg_err_r;
   assign err_code    = err_code_r;
   assign stat_good   = stat_good_r;
   assign stat_err    = stat_err_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with MSG_BYTES = 4 and TIMEOUT_CYCLES = 200.
module tb_uart_rx_ctrl;

   localparam int MB = 4;
   localparam int TO = 200;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          cfg_wr;
   logic [2:0]    cfg_baud;
   logic [2:0]    baud_select;
   logic          Rx_EN;
   logic [7:0]    Rx_DATA;
   logic          Rx_VALID;
   logic          Rx_FERROR;
   logic          Rx_PERROR;
   logic [31:0]   msg_data;
   logic [4:0]    msg_count;
   logic          msg_valid;
   logic          msg_ready;
   logic          msg_err;
   logic [1:0]    err_code;
   logic          busy;
   logic [15:0]   stat_good;
   logic [15:0]   stat_err;
   logic          stats_clr;

   int total  = 0;
   int passed = 0;

   uart_rx_ctrl #(.MSG_BYTES(MB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .cfg_wr(cfg_wr), .cfg_baud(cfg_baud),
      .baud_select(baud_select), .Rx_EN(Rx_EN), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
      .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .msg_data(msg_data),
      .msg_count(msg_count), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .msg_err(msg_err), .err_code(err_code), .busy(busy), .stat_good(stat_good),
      .stat_err(stat_err), .stats_clr(stats_clr)
   );

   always #5 clk = ~clk;

   // term: 0 none, 1 framing, 2 parity, 3 both flags, 4 timeout
   typedef struct {
      logic [31:0] bytes;
      int          n_good;
      int          term;
      int          hold;
      logic [31:0] exp_data;
      logic [4:0]  exp_count;
      logic        exp_err;
      logic [1:0]  exp_code;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      @(negedge clk);
      Rx_DATA  = d;
      Rx_VALID = 1'b1;
      @(negedge clk);
      Rx_VALID = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_err(input logic f, input logic p);
      @(negedge clk);
      Rx_FERROR = f;
      Rx_PERROR = p;
      @(negedge clk);
      Rx_FERROR = 1'b0;
      Rx_PERROR = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!msg_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid", {31'd0, msg_valid}, 32'd1);
   endtask

   task automatic consume(input logic clr);
      msg_ready = 1'b1;
      stats_clr = clr;
      @(negedge clk);
      msg_ready = 1'b0;
      stats_clr = 1'b0;
      check("hs_valid", {31'd0, msg_valid}, 32'd0);
      check("hs_count", {27'd0, msg_count}, 32'd0);
      check("hs_err", {29'd0, msg_err, err_code}, 32'd0);
      check("hs_rxen", {31'd0, Rx_EN}, {31'd0, enable});
   endtask

   initial begin
      logic [63:0] mask;
      reset = 1'b0; enable = 1'b0; cfg_wr = 1'b0; cfg_baud = 3'd0;
      Rx_DATA = 8'd0; Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
      msg_ready = 1'b0; stats_clr = 1'b0;

      tbl[0] = '{32'hF00FA555, 4, 0, 50, 32'hF00FA555, 5'd4, 1'b0, 2'b00};
      tbl[1] = '{32'h00002211, 2, 3, 0,  32'h00002211, 5'd2, 1'b1, 2'b01};
      tbl[2] = '{32'h0000003C, 1, 4, 0,  32'h0000003C, 5'd1, 1'b1, 2'b11};
      tbl[3] = '{32'h00000000, 0, 2, 3,  32'h00000000, 5'd0, 1'b1, 2'b10};
      tbl[4] = '{32'h04030201, 4, 0, 0,  32'h04030201, 5'd4, 1'b0, 2'b00};
      tbl[5] = '{32'h00CCBBAA, 3, 1, 0,  32'h00CCBBAA, 5'd3, 1'b1, 2'b01};

      repeat (3) @(negedge clk);
      check("rst_baud", {29'd0, baud_select}, 32'd7);
      check("rst_flags", {28'd0, Rx_EN, busy, msg_valid, msg_err}, 32'd0);
      check("rst_msg", {25'd0, msg_count, err_code}, 32'd0);
      check("rst_data", msg_data, 32'd0);
      reset = 1'b1;

      // baud programming only takes effect in IDLE
      @(negedge clk);
      cfg_wr = 1'b1; cfg_baud = 3'b011;
      @(negedge clk);
      cfg_wr = 1'b0;
      check("cfg_idle", {29'd0, baud_select}, 32'd3);
      enable = 1'b1;
      @(negedge clk);
      check("en_rxen_busy", {30'd0, Rx_EN, busy}, 32'd3);
      cfg_wr = 1'b1; cfg_baud = 3'b101;
      @(negedge clk);
      cfg_wr = 1'b0;
      check("cfg_collect", {29'd0, baud_select}, 32'd3);

      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < tbl[i].n_good; k++) begin
            send_byte(tbl[i].bytes[8*k +: 8], 2);
         end
         case (tbl[i].term)
            1: send_err(1'b1, 1'b0);
            2: send_err(1'b0, 1'b1);
            3: send_err(1'b1, 1'b1);
            default: ;
         endcase
         wait_valid();
         repeat (tbl[i].hold) @(negedge clk);
         mask = (64'd1 << (8 * tbl[i].exp_count)) - 64'd1;
         check($sformatf("v%0d_data", i), msg_data & mask[31:0], tbl[i].exp_data & mask[31:0]);
         check($sformatf("v%0d_count", i), {27'd0, msg_count}, {27'd0, tbl[i].exp_count});
         check($sformatf("v%0d_err", i), {29'd0, msg_err, err_code},
               {29'd0, tbl[i].exp_err, tbl[i].exp_code});
         check($sformatf("v%0d_valid_rxen", i), {30'd0, msg_valid, Rx_EN}, 32'd2);
         consume(1'b0);
      end

      // timeout lands exactly TO cycles after the byte store
      @(negedge clk);
      Rx_DATA = 8'h3C; Rx_VALID = 1'b1;
      @(negedge clk);
      Rx_VALID = 1'b0;
      check("to_store", {27'd0, msg_count}, 32'd1);
      repeat (TO - 1) @(negedge clk);
      check("to_early", {31'd0, msg_valid}, 32'd0);
      @(negedge clk);
      check("to_fire", {29'd0, msg_valid, err_code}, 32'h7);
      check("to_count", {27'd0, msg_count}, 32'd1);
      consume(1'b0);

      // a byte on the expiry cycle wins over the timeout
      @(negedge clk);
      Rx_DATA = 8'h10; Rx_VALID = 1'b1;
      @(negedge clk);
      Rx_VALID = 1'b0;
      repeat (TO - 1) @(negedge clk);
      Rx_DATA = 8'h20; Rx_VALID = 1'b1;
      @(negedge clk);
      Rx_VALID = 1'b0;
      check("race_novalid", {29'd0, msg_valid, err_code}, 32'd0);
      check("race_count", {27'd0, msg_count}, 32'd2);
      send_byte(8'h30, 2);
      send_byte(8'h40, 2);
      wait_valid();
      check("race_data", msg_data, 32'h40302010);
      check("race_err", {31'd0, msg_err}, 32'd0);
      consume(1'b0);

      // abort after three bytes
      send_byte(8'hE1, 1);
      send_byte(8'hE2, 1);
      send_byte(8'hE3, 1);
      check("ab_count3", {27'd0, msg_count}, 32'd3);
      enable = 1'b0;
      @(negedge clk);
      check("ab_idle", {28'd0, busy, Rx_EN, msg_valid, msg_err}, 32'd0);
      check("ab_count0", {27'd0, msg_count}, 32'd0);
      repeat (20) @(negedge clk);
      check("ab_novalid", {31'd0, msg_valid}, 32'd0);
      enable = 1'b1;
      @(negedge clk);
      send_byte(8'h77, 1);
      check("ab_restart", {27'd0, msg_count}, 32'd1);
      send_byte(8'h88, 1);
      send_byte(8'h99, 1);
      send_byte(8'h66, 1);
      wait_valid();
      check("ab_data", msg_data, 32'h66998877);
      consume(1'b0);

      // asynchronous reset while a message is pending
      send_byte(8'h01, 1);
      send_byte(8'h02, 1);
      send_byte(8'h03, 1);
      send_byte(8'h04, 1);
      wait_valid();
      #2 reset = 1'b0;
      #1;
      check("ar_flags", {28'd0, Rx_EN, busy, msg_valid, msg_err}, 32'd0);
      check("ar_msg", {25'd0, msg_count, err_code}, 32'd0);
      check("ar_data", msg_data, 32'd0);
      check("ar_baud", {29'd0, baud_select}, 32'd7);
      check("ar_stats", {stat_good, stat_err}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // statistics: three good and one timeout message, then clear on a good handshake
      for (int m = 0; m < 3; m++) begin
         for (int k = 0; k < MB; k++) send_byte(8'(m * 16 + k), 1);
         wait_valid();
         consume(1'b0);
      end
      send_byte(8'h5A, 1);
      wait_valid();
      consume(1'b0);
`ifdef UART_RX_CTRL_STATS_EN
      check("st_good", {16'd0, stat_good}, 32'd3);
      check("st_err", {16'd0, stat_err}, 32'd1);
`else
      check("st_good", {16'd0, stat_good}, 32'd0);
      check("st_err", {16'd0, stat_err}, 32'd0);
`endif
      for (int k = 0; k < MB; k++) send_byte(8'hC0 + 8'(k), 1);
      wait_valid();
      consume(1'b1);
      check("st_clr", {stat_good, stat_err}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing controller for uart_receiver. Programs baud_select, gates Rx_EN and collects MSG_BYTES consecutive received bytes into one message word. Error frames and inter-byte timeouts terminate the message with a coded error. Completed messages go to a consumer through a valid/ready handshake; Rx_EN is held low while delivery is pending.

Parameters:
MSG_BYTES, 4, bytes per message (range 1..16).
TIMEOUT_CYCLES, 8680, maximum clk cycles between bytes inside one message (two byte times at 115200 baud on a 50 MHz clk).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
enable  in  1  level; 1 = controller runs.
cfg_wr  in  1  one-cycle strobe that loads cfg_baud.
cfg_baud  in  3  baud code for the receiver.
baud_select  out  3  to uart_receiver.baud_select.
Rx_EN  out  1  to uart_receiver.Rx_EN.
Rx_DATA  in  8  from receiver.
Rx_VALID  in  1  from receiver.
Rx_FERROR  in  1  from receiver.
Rx_PERROR  in  1  from receiver.
msg_data  out  8*MSG_BYTES  assembled message; first byte in [7:0].
msg_count  out  5  number of bytes held in msg_data.
msg_valid  out  1  message available.
msg_ready  in  1  consumer accepts.
msg_err  out  1  message terminated by an error.
err_code  out  2  00 none, 01 framing, 10 parity, 11 timeout.
busy  out  1  high in any state other than IDLE.
stat_good  out  16  see Optional Feature.
stat_err  out  16  see Optional Feature.
stats_clr  in  1  see Optional Feature.

Behaviour:
- Reset (asynchronous, active low) clears everything. State = IDLE, baud_select = 3'b111, Rx_EN = 0, msg_valid = 0, msg_err = 0, err_code = 00, msg_count = 0, msg_data = 0, busy = 0, timer = 0, edge registers = 0.
- Byte event: rising edge of Rx_VALID, Rx_FERROR or Rx_PERROR, each detected against its own value registered on the previous cycle. An input held high counts once.
- Error classification on a byte event: Rx_FERROR high gives code 01. Otherwise Rx_PERROR high gives code 10. Framing wins when both are high.
- IDLE:
  - Rx_EN = 0.
  - cfg_wr loads baud_select from cfg_baud. cfg_wr is ignored in every other state.
  - When enable = 1, go to COLLECT. Rx_EN goes high the following cycle.
- COLLECT, Rx_EN = 1:
  - Good byte event at cycle N: Rx_DATA is written to slot msg_count at the N+1 edge, msg_count increments, and the timer is cleared.
  - When the write fills slot MSG_BYTES-1, go to DELIVER. msg_valid rises at N+1 and Rx_EN drops at N+1.
  - Error byte event: data is not stored; err_code is set and the state goes to DELIVER with msg_err = 1.
  - Timer counts only while 1 <= msg_count < MSG_BYTES. When it reaches TIMEOUT_CYCLES-1 the state goes to DELIVER with msg_err = 1 and err_code = 11.
  - A byte event in the same cycle as timer expiry: the byte wins and the timer is cleared.
  - enable = 0 aborts: partial data is discarded, msg_count = 0, next state IDLE, no message is delivered.
- DELIVER, msg_valid = 1, Rx_EN = 0:
  - msg_data, msg_count, msg_err and err_code stay stable until msg_ready = 1 while msg_valid = 1.
  - On that handshake cycle: msg_valid = 0, msg_err = 0, err_code = 00, msg_count = 0 and timer = 0 at the next edge.
  - Next state is COLLECT if enable = 1, otherwise IDLE.
  - enable falling during DELIVER does not cancel the pending message.
- An error or timeout message carries the good bytes received so far; msg_count gives how many (0 when the first byte itself had an error).
- Stale data above msg_count in msg_data is don't-care.
- Byte events are ignored outside COLLECT.
- Edge registers update in every state, so a Rx_VALID level left over from DELIVER does not fire on re-entry to COLLECT.

Optional Feature:
Macro UART_RX_CTRL_STATS_EN.
- Defined:
  - stat_good increments once per accepted handshake with msg_err = 0.
  - stat_err increments once per accepted handshake with msg_err = 1.
  - Both are 16-bit, saturating at 16'hFFFF.
  - stats_clr zeroes both synchronously and has priority over increment.
  - reset zeroes both.
- Not defined: stat_good and stat_err are tied to 0 and stats_clr is ignored. Ports are present in both builds.

Test Plan:
- Reset release, cfg_wr with cfg_baud = 3'b011 in IDLE -> baud_select = 011. A later cfg_wr with cfg_baud = 3'b101 while in COLLECT -> baud_select stays 011.
- MSG_BYTES = 4, enable = 1, stub pulses Rx_VALID with 8'h55, 8'hA5, 8'h0F, 8'hF0 -> msg_data = 32'hF00FA555, msg_count = 4, msg_err = 0, Rx_EN = 0 while msg_ready is held 0 for 50 cycles, msg_valid drops one cycle after msg_ready = 1.
- Two good bytes, then Rx_FERROR and Rx_PERROR rise together -> msg_err = 1, err_code = 01, msg_count = 2, msg_data[15:0] holds both bytes.
- TIMEOUT_CYCLES = 200, one byte 8'h3C then silence -> err_code = 11 exactly 200 cycles after the byte store, msg_count = 1. A second run sends its second byte on the expiry cycle -> no timeout.
- enable dropped after 3 bytes -> IDLE, no msg_valid, next message starts at msg_count = 0. reset asserted during DELIVER -> all outputs at reset values immediately, without waiting for a clock edge.
- STATS build: 3 good messages plus 1 timeout message -> stat_good = 3, stat_err = 1. stats_clr pulsed on the same cycle as a good handshake -> both counters read 0.
